// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared encodings and helpers for the sized data memory:
//               access-size codes, controller state enum, word width and
//               the alignment check used for request screening.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    localparam int c_word_w         = 32;
    localparam int c_bytes_per_word = c_word_w / 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // True when the access cannot be performed: illegal size code or an
    // offset that is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering. Extracts and extends load
//               data from a raw storage word, and places store data into
//               lanes with matching byte enables. Lane k of the storage word
//               always holds the byte at word offset k; BIG_ENDIAN only
//               changes how multi-byte values map onto those lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import data_memory_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword
);

    logic [3:0][7:0] w_lanes;
    logic [3:0][7:0] w_st;
    logic [1:0]      w_h0;
    logic [1:0]      w_h1;
    logic [15:0]     w_half;

    assign w_lanes = i_rword;
    // Lane pair of a half access; bit 0 of the offset is ignored because
    // misaligned halves never reach the array.
    assign w_h0    = {i_offset[1], 1'b0};
    assign w_h1    = {i_offset[1], 1'b1};
    assign o_wword = w_st;

    // Load path: gather addressed lanes, right-justify, then extend.
    always_comb begin
        o_load = '0;
        w_half = (BIG_ENDIAN != 0) ? {w_lanes[w_h0], w_lanes[w_h1]}
                                   : {w_lanes[w_h1], w_lanes[w_h0]};
        case (i_size)
            SIZE_BYTE: o_load = {{24{i_sign_ext & w_lanes[i_offset][7]}},
                                 w_lanes[i_offset]};
            SIZE_HALF: o_load = {{16{i_sign_ext & w_half[15]}}, w_half};
            SIZE_WORD: o_load = (BIG_ENDIAN != 0)
                              ? {w_lanes[0], w_lanes[1], w_lanes[2], w_lanes[3]}
                              : i_rword;
            default:   o_load = '0;
        endcase
    end

    // Store path: drop the low bits of write data into the addressed lanes.
    always_comb begin
        o_be = 4'b0000;
        w_st = '0;
        case (i_size)
            SIZE_BYTE: begin
                o_be[i_offset] = 1'b1;
                w_st[i_offset] = i_wdata[7:0];
            end
            SIZE_HALF: begin
                o_be[w_h0] = 1'b1;
                o_be[w_h1] = 1'b1;
                if (BIG_ENDIAN != 0) begin
                    w_st[w_h0] = i_wdata[15:8];
                    w_st[w_h1] = i_wdata[7:0];
                end else begin
                    w_st[w_h0] = i_wdata[7:0];
                    w_st[w_h1] = i_wdata[15:8];
                end
            end
            SIZE_WORD: begin
                o_be = 4'b1111;
                if (BIG_ENDIAN != 0) begin
                    w_st = {i_wdata[7:0], i_wdata[15:8],
                            i_wdata[23:16], i_wdata[31:24]};
                end else begin
                    w_st = i_wdata;
                end
            end
            default: begin
                o_be = 4'b0000;
                w_st = '0;
            end
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_sized
// Description : Byte-addressed data memory with byte/half/word accesses,
//               alignment checking, one-cycle registered loads and an
//               optional post-reset clear sweep (one word per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_sized
    import data_memory_pkg::*;
#(
    parameter int MEM_BYTES      = 1024,
    parameter int ADDR_W         = 18,
    parameter int BIG_ENDIAN     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adress,
    input  logic [31:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              access_err,
    output logic              ready
);

    localparam int c_words   = MEM_BYTES / c_bytes_per_word;
    localparam int c_byte_aw = $clog2(MEM_BYTES);
    localparam int c_widx_w  = $clog2(c_words);
    localparam logic [c_widx_w-1:0] c_last_word = c_widx_w'(c_words - 1);
    localparam state_t c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [31:0]          r_mem [0:c_words-1];
    state_t               r_state;
    state_t               w_next_state;
    logic [c_widx_w-1:0]  r_clr_cnt;
    logic [c_widx_w-1:0]  w_next_cnt;
    logic                 r_ready;
    logic                 w_next_ready;
    logic [31:0]          r_read_data;
    logic                 r_read_valid;
    logic                 r_access_err;

    logic [c_byte_aw-1:0] w_eff;
    logic [c_widx_w-1:0]  w_widx;
    logic [1:0]           w_off;
    logic [31:0]          w_rword;
    logic                 w_bad;
    logic                 w_accept;
    logic                 w_store;
    logic [31:0]          w_load;
    logic [3:0]           w_be;
    logic [31:0]          w_wword;
    logic [31:0]          w_mask;
    logic                 w_we;
    logic [c_widx_w-1:0]  w_waddr;
    logic [31:0]          w_wdata;

    // Addresses wrap modulo the capacity, so upper address bits are dropped.
    generate
        if (ADDR_W > c_byte_aw) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^adress[ADDR_W-1:c_byte_aw];
        end
    endgenerate

    assign w_eff    = adress[c_byte_aw-1:0];
    assign w_widx   = w_eff[c_byte_aw-1:2];
    assign w_off    = w_eff[1:0];
    assign w_rword  = r_mem[w_widx];
    assign w_bad    = is_misaligned(size, w_off);
    assign w_accept = r_ready & (mem_read | mem_write);
    assign w_store  = w_accept & mem_write & ~w_bad;
    assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .i_offset   (w_off),
        .i_size     (size),
        .i_sign_ext (sign_ext),
        .i_rword    (w_rword),
        .i_wdata    (write_data),
        .o_load     (w_load),
        .o_be       (w_be),
        .o_wword    (w_wword)
    );

    // State and clear-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_reset_state;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_clr_cnt <= w_next_cnt;
            r_ready   <= w_next_ready;
        end
    end

    // Next-state logic: sweep every word once, then serve requests.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == c_last_word) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = c_reset_state;
                w_next_cnt   = '0;
            end
        endcase
        w_next_ready = (w_next_state == ST_IDLE);
    end

    // Single array write port: clear sweep or read-modify-write of a store.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_widx;
        w_wdata = (w_rword & ~w_mask) | (w_wword & w_mask);
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = '0;
        end else if (w_store) begin
            w_we    = 1'b1;
        end
    end

    // Storage array; reset never touches its contents.
    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Response registers: load data and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            r_access_err <= 1'b0;
            if (w_accept) begin
                if (w_bad) begin
                    r_access_err <= 1'b1;
                end else if (mem_read) begin
                    r_read_data  <= w_load;
                    r_read_valid <= 1'b1;
                end
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign access_err = r_access_err;
    assign ready      = r_ready;

endmodule : data_memory_sized
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_sized
// Description : Self-checking bench for data_memory_sized with a byte-array
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_sized;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 18;
    localparam int BE        = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] adress;
    logic [31:0]       write_data;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       read_data;
    logic              read_valid;
    logic              access_err;
    logic              ready;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  mm [0:MEM_BYTES-1];
    logic [31:0] exp_rd;

    data_memory_sized #(
        .MEM_BYTES      (MEM_BYTES),
        .ADDR_W         (ADDR_W),
        .BIG_ENDIAN     (BE),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adress     (adress),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .read_data  (read_data),
        .read_valid (read_valid),
        .access_err (access_err),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mload(input int ea, input int n, input bit sx);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (BE != 0) v = (v << 8) | 32'(mm[ea + i]);
            else         v = v | (32'(mm[ea + i]) << (8 * i));
        end
        if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic mstore(input int ea, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            if (BE != 0) mm[ea + i] = 8'(wd >> (8 * (n - 1 - i)));
            else         mm[ea + i] = 8'(wd >> (8 * i));
        end
    endtask

    // One request cycle: drive at negedge, predict, check at following negedge.
    task automatic step(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [1:0] sz, input bit sx, input logic [31:0] wd,
                        input string tag);
        int   ea;
        int   n;
        bit   legal;
        logic e_rv;
        logic e_err;
        mem_read   = rd;
        mem_write  = wr;
        adress     = a;
        size       = sz;
        sign_ext   = sx;
        write_data = wd;
        ea    = int'(a) % MEM_BYTES;
        n     = (sz == 2'b11) ? 4 : (1 << sz);
        legal = (sz != 2'b11) && (ea % n == 0);
        e_rv  = 1'b0;
        e_err = 1'b0;
        if (rd || wr) begin
            if (!legal) begin
                e_err = 1'b1;
            end else begin
                if (rd) begin
                    exp_rd = mload(ea, n, sx);
                    e_rv   = 1'b1;
                end
                if (wr) mstore(ea, n, wd);
            end
        end
        @(negedge clk);
        chk({tag, ":rdata"}, read_data, exp_rd);
        chk({tag, ":rvalid"}, {31'b0, read_valid}, {31'b0, e_rv});
        chk({tag, ":err"}, {31'b0, access_err}, {31'b0, e_err});
        chk({tag, ":ready"}, {31'b0, ready}, 32'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
        exp_rd     = '0;
        reset      = 1'b1;
        adress     = '0;
        write_data = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b00;
        sign_ext   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_rvalid", {31'b0, read_valid}, 32'd0);
        chk("rst_err", {31'b0, access_err}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);

        // Abort the clear sweep at cycle 100 and require a full restart.
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("midclear_ready", {31'b0, ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midclear_rst_ready", {31'b0, ready}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        while (!ready && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("clear_cycles", cnt, 32'd256);

        step(1, 0, 18'h003FC, 2'b10, 0, 0, "ld_3fc");
        chk("ld_3fc_zero", read_data, 32'h0);

        // Endianness and extension.
        step(0, 1, 18'h00010, 2'b10, 0, 32'hAABBCCDD, "st_w10");
        step(1, 0, 18'h00010, 2'b00, 1, 0, "ldb10");
        chk("ldb10_val", read_data, 32'hFFFFFFAA);
        step(1, 0, 18'h00011, 2'b00, 1, 0, "ldb11");
        chk("ldb11_val", read_data, 32'hFFFFFFBB);
        step(1, 0, 18'h00012, 2'b00, 1, 0, "ldb12");
        chk("ldb12_val", read_data, 32'hFFFFFFCC);
        step(1, 0, 18'h00013, 2'b00, 1, 0, "ldb13");
        chk("ldb13_val", read_data, 32'hFFFFFFDD);
        step(1, 0, 18'h00012, 2'b01, 0, 0, "ldh12");
        chk("ldh12_val", read_data, 32'h0000CCDD);
        step(0, 1, 18'h00010, 2'b01, 0, 32'h00001234, "st_h10");
        step(1, 0, 18'h00010, 2'b10, 0, 0, "ldw10");
        chk("ldw10_val", read_data, 32'h1234CCDD);

        // Rejected requests leave data and memory alone.
        step(1, 0, 18'h00011, 2'b10, 0, 0, "err_w11");
        step(1, 0, 18'h00013, 2'b01, 0, 0, "err_h13");
        step(1, 0, 18'h00000, 2'b11, 0, 0, "err_sz3");
        step(0, 1, 18'h00011, 2'b10, 0, 32'hDEADBEEF, "err_st11");
        step(0, 1, 18'h00010, 2'b11, 0, 32'hDEADBEEF, "err_st_sz3");
        step(1, 0, 18'h00010, 2'b10, 0, 0, "ldw10_again");
        chk("ldw10_unchanged", read_data, 32'h1234CCDD);

        // Read-during-write, write-then-read and aliasing.
        step(0, 1, 18'h00020, 2'b10, 0, 32'h00000011, "st_w20");
        step(1, 1, 18'h00020, 2'b10, 0, 32'h00000055, "rw_w20");
        chk("rw_old", read_data, 32'h00000011);
        step(1, 0, 18'h00020, 2'b10, 0, 0, "ld_new");
        chk("ld_new_val", read_data, 32'h00000055);
        step(1, 0, 18'h00420, 2'b10, 0, 0, "ld_alias");
        chk("ld_alias_val", read_data, 32'h00000055);

        // Back-to-back random traffic over a small aliased window.
        for (int k = 0; k < 400; k++) begin
            ra = ADDR_W'(($urandom_range(0, 255) << 10) | $urandom_range(0, 63));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "rnd");
        end

        // Reset sampled together with a request: no response may appear.
        mem_read = 1'b1;
        adress   = 18'h00010;
        size     = 2'b10;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_req_rvalid", {31'b0, read_valid}, 32'd0);
        chk("rst_req_rdata", read_data, 32'h0);
        chk("rst_req_ready", {31'b0, ready}, 32'd0);
        size = 2'b11;
        @(negedge clk);
        chk("rst_bad_err", {31'b0, access_err}, 32'd0);
        mem_read = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_data_memory_sized
`default_nettype wire
